bit_debouncer: RTL and testbench

Synchronous debouncer and edge detector that sits directly downstream of the `dff` register stage and consumes its `q` output. It qualifies a level change only after the input has held steady for a programmable number of consecutive clocks. It then produces a clean level, single-cycle rise/fall pulses, and a wrapping count of qualified edges. It is the first stage that downstream control logic trusts.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/bit_debouncer.sv | 128 ++++++++++++
 tb/tb_bit_debouncer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and limits for the bit debouncer: FSM encoding and the
// minimum legal qualification length.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_CHK_HIGH,
        S_HIGH,
        S_CHK_LOW
    } deb_state_t;

    localparam int DEB_MIN_STABLE = 2;
    localparam int DEB_MAX_STABLE = 255;

    function automatic bit deb_stable_ok(input int n);
        return (n >= DEB_MIN_STABLE) && (n <= DEB_MAX_STABLE);
    endfunction

endpackage

// File: rtl/bit_debouncer.sv
// Debouncer and edge detector: accepts a new level after STABLE_CYCLES
// consecutive enabled samples, emitting rise/fall pulses and an edge count.
module bit_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             en,
    input  logic             count_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count
);

    localparam int               TMR_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    if (!deb_stable_ok(STABLE_CYCLES)) begin : g_bad_stable
        $error("bit_debouncer: STABLE_CYCLES out of legal range");
    end

    deb_state_t       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rise_d, fall_d;
    logic             level_q, rise_q, fall_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOW;
            timer_q <= '0;
        end else if (en) begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // timer holds the number of consecutive samples seen at the candidate level
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (d_in) begin
                    state_d = S_CHK_HIGH;
                    timer_d = TMR_ONE;
                end else begin
                    timer_d = '0;
                end
            end
            S_CHK_HIGH: begin
                if (!d_in) begin
                    state_d = S_LOW;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_HIGH;
                    timer_d = '0;
                    rise_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_HIGH: begin
                if (!d_in) begin
                    state_d = S_CHK_LOW;
                    timer_d = TMR_ONE;
                end else begin
                    timer_d = '0;
                end
            end
            S_CHK_LOW: begin
                if (d_in) begin
                    state_d = S_HIGH;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_LOW;
                    timer_d = '0;
                    fall_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                timer_d = '0;
            end
        endcase
    end

    // clear wins over a coincident increment; the pulse itself still fires
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
        end else begin
            rise_q <= en & rise_d;
            fall_q <= en & fall_d;
            if (en) begin
                if (rise_d) begin
                    level_q <= 1'b1;
                end else if (fall_d) begin
                    level_q <= 1'b0;
                end
                if (count_clr) begin
                    count_q <= '0;
                end else if (rise_d || fall_d) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign edge_count = count_q;

endmodule

// File: tb/tb_bit_debouncer.sv
// Bench for bit_debouncer fed through a dff stage; a run-length reference
// model is compared against the outputs after every clock edge.
module tb_bit_debouncer;

    localparam int SC = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          raw = 1'b0;
    logic          dff_q;
    logic          en = 1'b0;
    logic          count_clr = 1'b0;
    logic          level_out, rise_pulse, fall_pulse;
    logic [CW-1:0] edge_count;

    int checks = 0;
    int errors = 0;
    int n_rise = 0;
    int n_fall = 0;
    bit mon_on = 1'b0;

    int m_level = 0;
    int m_run   = 0;
    int m_rise  = 0;
    int m_fall  = 0;
    int m_cnt   = 0;

    always #10 clk = ~clk;

    // upstream dff stage
    always_ff @(posedge clk) dff_q <= raw;

    bit_debouncer #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (dff_q),
        .en         (en),
        .count_clr  (count_clr),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_count (edge_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: count consecutive enabled samples that differ from the
    // accepted level; SC of them in a row flip the level.
    always @(posedge clk) begin
        int d;
        d = (dff_q === 1'b1) ? 1 : 0;
        if (rst) begin
            m_level = 0; m_run = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (en) begin
                if (d != m_level) begin
                    m_run++;
                    if (m_run == SC) begin
                        m_level = d;
                        m_run   = 0;
                        m_rise  = d;
                        m_fall  = 1 - d;
                        m_cnt   = (m_cnt + 1) % (1 << CW);
                    end
                end else begin
                    m_run = 0;
                end
                if (count_clr) m_cnt = 0;
            end
        end
        #1;
        if (mon_on) begin
            check("level", 32'(level_out), 32'(m_level));
            check("rise", 32'(rise_pulse), 32'(m_rise));
            check("fall", 32'(fall_pulse), 32'(m_fall));
            check("count", 32'(edge_count), 32'(m_cnt));
            check("excl", 32'(rise_pulse & fall_pulse), 32'd0);
            if (rise_pulse) n_rise++;
            if (fall_pulse) n_fall++;
        end
    end

    task automatic drive(input logic r, input logic d, input logic e, input logic c);
        @(negedge clk);
        rst = r; raw = d; en = e; count_clr = c;
    endtask

    task automatic hold(input logic d, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, d, 1'b1, 1'b0);
    endtask

    initial begin
        int r0, f0, len;
        logic lv;

        // reset held with a high input
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        mon_on = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_count", 32'(edge_count), 32'd0);
        check("rst_rises", 32'(n_rise), 32'd0);
        rst = 1'b0; raw = 1'b0; en = 1'b1;

        // clean rise
        hold(1'b0, 6);
        r0 = n_rise;
        hold(1'b1, 8);
        check("rise_once", 32'(n_rise - r0), 32'd1);
        check("rise_level", 32'(level_out), 32'd1);
        check("rise_count", 32'(edge_count), 32'd1);

        // back low, then a 3-sample glitch
        hold(1'b0, 8);
        check("fall_level", 32'(level_out), 32'd0);
        r0 = n_rise;
        hold(1'b1, 3);
        hold(1'b0, 8);
        check("glitch_rises", 32'(n_rise - r0), 32'd0);
        check("glitch_count", 32'(edge_count), 32'd2);

        // enable freeze in the middle of a run
        r0 = n_rise;
        hold(1'b1, 2);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'(i), 1'b0, 1'b0);
        hold(1'b1, 8);
        check("freeze_rises", 32'(n_rise - r0), 32'd1);
        check("freeze_count", 32'(edge_count), 32'd3);

        // clear, then 17 alternating edges wrap a 4-bit counter
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 2);
        check("clr_idle", 32'(edge_count), 32'd0);
        lv = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lv = ~lv;
            hold(lv, 6);
        end
        check("wrap_count", 32'(edge_count), 32'd1);

        // clear coincident with an accepted edge
        lv = ~lv;
        hold(lv, 4);
        drive(1'b0, lv, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        check("clr_pulse", 32'(rise_pulse | fall_pulse), 32'd1);
        check("clr_count", 32'(edge_count), 32'd0);
        hold(lv, 3);

        // mid-check reset
        hold(1'b0, 8);
        r0 = n_rise;
        hold(1'b1, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        hold(1'b1, 3);
        check("midrst_early", 32'(n_rise - r0), 32'd0);
        hold(1'b1, 3);
        check("midrst_rise", 32'(n_rise - r0), 32'd1);

        // randomized traffic
        r0 = n_rise; f0 = n_fall;
        for (int i = 0; i < 120; i++) begin
            lv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
                logic e, c, r;
                e = ($urandom_range(0, 9) != 0);
                c = e && ($urandom_range(0, 29) == 0);
                r = ($urandom_range(0, 99) == 0);
                drive(r, lv, e, c);
            end
        end
        hold(1'b0, 2);
        check("rand_activity", 32'((n_rise - r0) + (n_fall - f0) > 0), 32'd1);

        mon_on = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
